// File: rtl/poly_sub_decode_if.sv
// Stream bundle for poly_sub_decode: (v, sᵀu) coefficient pairs in,
// reduced coefficient with its decoded bit, index and range flag out.
interface poly_sub_decode_if #(
    parameter int DATA_WID = 12,
    parameter int IDX_W    = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_WID-1:0] in_v;
    logic [DATA_WID-1:0] in_w;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_WID-1:0] out_coeff;
    logic                out_bit;
    logic [IDX_W-1:0]    out_idx;
    logic                out_last;
    logic                range_err;

    modport master (
        output in_valid, in_v, in_w, out_ready,
        input  in_ready, out_valid, out_coeff, out_bit, out_idx, out_last, range_err
    );

    modport slave (
        input  in_valid, in_v, in_w, out_ready,
        output in_ready, out_valid, out_coeff, out_bit, out_idx, out_last, range_err
    );
endinterface

// File: rtl/poly_sub_decode.sv
// Decapsulation back-end: w' = (v - sᵀu) mod Q per coefficient, decoded to a
// message bit, in a 2-stage stall-together pipeline with a running index.
module poly_sub_decode #(
    parameter int DATA_WID = 12,
    parameter int Q        = 3329,
    parameter int N_COEFF  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    poly_sub_decode_if.slave  bus
);
    localparam int IDX_W  = $clog2(N_COEFF);
    localparam int DIFF_W = DATA_WID + 1;

    localparam logic [DATA_WID-1:0]      Q_U      = DATA_WID'(Q);
    localparam logic signed [DIFF_W-1:0] Q_S      = DIFF_W'(Q);
    localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(N_COEFF - 1);
    // Bit is 1 when round(2c/Q) is odd: c in [ceil(Q/4), floor(3Q/4)].
    localparam logic [DATA_WID-1:0]      DEC_LO   = DATA_WID'((Q + 3) / 4);
    localparam logic [DATA_WID-1:0]      DEC_HI   = DATA_WID'((3 * Q) / 4);

    function automatic logic [DATA_WID-1:0] mod_q(input logic signed [DIFF_W-1:0] d);
        logic signed [DIFF_W-1:0] t;
        t = d[DIFF_W-1] ? d + Q_S : d;
        return t[DATA_WID-1:0];
    endfunction

    function automatic logic decode_bit(input logic [DATA_WID-1:0] c);
        return (c >= DEC_LO) && (c <= DEC_HI);
    endfunction

    logic                     en;
    logic                     xfer_in;
    logic                     oor;
    logic [IDX_W-1:0]         idx_cnt;
    logic                     err_q;

    logic                     vld_p1;
    logic signed [DIFF_W-1:0] diff_p1;
    logic [IDX_W-1:0]         idx_p1;
    logic [DATA_WID-1:0]      coeff_s2;

    logic                     vld_p2;
    logic [DATA_WID-1:0]      coeff_p2;
    logic                     bit_p2;
    logic [IDX_W-1:0]         idx_p2;
    logic                     last_p2;

    // Whole pipe advances together; in_ready derives only from output state.
    assign en       = !vld_p2 || bus.out_ready;
    assign xfer_in  = bus.in_valid && en;
    assign oor      = (bus.in_v >= Q_U) || (bus.in_w >= Q_U);
    assign coeff_s2 = mod_q(diff_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_cnt  <= '0;
            err_q    <= 1'b0;
            vld_p1   <= 1'b0;
            diff_p1  <= '0;
            idx_p1   <= '0;
            vld_p2   <= 1'b0;
            coeff_p2 <= '0;
            bit_p2   <= 1'b0;
            idx_p2   <= '0;
            last_p2  <= 1'b0;
        end else begin
            if (xfer_in) begin
                idx_cnt <= (idx_cnt == IDX_LAST) ? '0 : idx_cnt + 1'b1;
                if (oor) err_q <= 1'b1;
            end
            if (en) begin
                // stage 1: signed difference, valid and index captured together
                vld_p1   <= bus.in_valid;
                diff_p1  <= $signed({1'b0, bus.in_v}) - $signed({1'b0, bus.in_w});
                idx_p1   <= idx_cnt;
                // stage 2: fold into 0..Q-1 and decode
                vld_p2   <= vld_p1;
                coeff_p2 <= coeff_s2;
                bit_p2   <= decode_bit(coeff_s2);
                idx_p2   <= idx_p1;
                last_p2  <= (idx_p1 == IDX_LAST);
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = vld_p2;
    assign bus.out_coeff = coeff_p2;
    assign bus.out_bit   = bit_p2;
    assign bus.out_idx   = idx_p2;
    assign bus.out_last  = last_p2;
    assign bus.range_err = err_q;
endmodule

// File: tb/tb_poly_sub_decode.sv
// Scoreboard bench for poly_sub_decode: driver pushes expected words on
// acceptance, an independent monitor pops and compares on output transfers.
module tb_poly_sub_decode;
    typedef struct {
        logic [11:0] coeff;
        logic        bt;
        logic [7:0]  idx;
        logic        last;
        bit          dc;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    poly_sub_decode_if bus ();
    poly_sub_decode dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   lat_chk = 0;
    int   tb_idx = 0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [11:0] ref_coeff(input int v, input int w);
        int d;
        d = v - w;
        if (d < 0) d += 3329;
        return 12'(d);
    endfunction

    function automatic bit ref_bit(input int c);
        return (c >= 833) && (c <= 2496);
    endfunction

    // Monitor: handshake relation, hold-while-stalled, scoreboard pops
    logic        stall_prev = 1'b0;
    logic [11:0] h_coeff;
    logic        h_bit;
    logic [7:0]  h_idx;
    logic        h_last;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rel", int'(bus.in_ready), int'(!(bus.out_valid && !bus.out_ready)));
            if (stall_prev) begin
                check("hold_valid", int'(bus.out_valid), 1);
                check("hold_coeff", int'(bus.out_coeff), int'(h_coeff));
                check("hold_bit",   int'(bus.out_bit),   int'(h_bit));
                check("hold_idx",   int'(bus.out_idx),   int'(h_idx));
                check("hold_last",  int'(bus.out_last),  int'(h_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    if (!mon_e.dc) begin
                        check("out_coeff", int'(bus.out_coeff), int'(mon_e.coeff));
                        check("out_bit",   int'(bus.out_bit),   int'(mon_e.bt));
                    end
                    check("out_idx",  int'(bus.out_idx),  int'(mon_e.idx));
                    check("out_last", int'(bus.out_last), int'(mon_e.last));
                    if (lat_chk) check("latency", cyc - mon_e.cyc, 2);
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            h_coeff = bus.out_coeff;
            h_bit   = bus.out_bit;
            h_idx   = bus.out_idx;
            h_last  = bus.out_last;
        end
    end

    task automatic drive(input bit vld, input logic [11:0] v, input logic [11:0] w,
                         input bit rdy, input logic [11:0] ec, input bit eb,
                         input bit dc, output bit acc);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid  = vld;
        bus.in_v      = v;
        bus.in_w      = w;
        bus.out_ready = rdy;
        @(negedge clk);
        acc = vld && bus.in_ready;
        if (acc) begin
            e.coeff = ec;
            e.bt    = eb;
            e.idx   = 8'(tb_idx);
            e.last  = (tb_idx == 255);
            e.dc    = dc;
            e.cyc   = cyc;
            sb.push_back(e);
            tb_idx = (tb_idx + 1) % 256;
        end
    endtask

    task automatic send_d(input int v, input int w, input int ec, input bit eb);
        bit acc;
        drive(1'b1, 12'(v), 12'(w), 1'b1, 12'(ec), eb, 1'b0, acc);
        check("send_accepted", int'(acc), 1);
    endtask

    task automatic send_m(input int v, input int w);
        logic [11:0] c;
        bit acc;
        c = ref_coeff(v, w);
        drive(1'b1, 12'(v), 12'(w), 1'b1, c, ref_bit(int'(c)), 1'b0, acc);
        if (!acc) check("send_accepted", 0, 1);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && sb.size() > 0; i++)
            drive(1'b0, 12'd0, 12'd0, 1'b1, 12'd0, 1'b0, 1'b0, acc);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        sb.delete();
        tb_idx = 0;
        @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_coeff", int'(bus.out_coeff), 0);
        check("rst_out_bit",   int'(bus.out_bit),   0);
        check("rst_out_idx",   int'(bus.out_idx),   0);
        check("rst_out_last",  int'(bus.out_last),  0);
        check("rst_range_err", int'(bus.range_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          got;
        bit          vv, rr;
        logic [11:0] v, w, c;

        bus.in_valid  = 1'b0;
        bus.in_v      = '0;
        bus.in_w      = '0;
        bus.out_ready = 1'b1;
        do_reset();

        // Directed values and decode boundaries, latency checked
        lat_chk = 1;
        send_d(5, 3, 2, 1'b0);
        send_d(3, 5, 3327, 1'b0);
        send_d(2000, 0, 2000, 1'b1);
        send_d(0, 0, 0, 1'b0);
        send_d(832, 0, 832, 1'b0);
        send_d(833, 0, 833, 1'b1);
        send_d(2496, 0, 2496, 1'b1);
        send_d(2497, 0, 2497, 1'b0);
        send_d(0, 2497, 832, 1'b0);
        send_d(0, 2496, 833, 1'b1);
        send_d(0, 833, 2496, 1'b1);
        send_d(0, 832, 2497, 1'b0);
        send_d(0, 1, 3328, 1'b0);
        send_d(3328, 0, 3328, 1'b0);
        drain();

        // Full stream: two polynomials back to back
        do_reset();
        for (int i = 0; i < 512; i++)
            send_m(int'($urandom_range(0, 3328)), int'($urandom_range(0, 3328)));
        drain();
        lat_chk = 0;

        // Backpressure with random bubbles
        got = 0;
        for (int i = 0; i < 5000 && got < 256; i++) begin
            vv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            v  = 12'($urandom_range(0, 3328));
            w  = 12'($urandom_range(0, 3328));
            c  = ref_coeff(int'(v), int'(w));
            drive(vv, v, w, rr, c, ref_bit(int'(c)), 1'b0, acc);
            if (acc) got++;
        end
        check("bp_accepted", got, 256);
        drain();

        // Range error mid-stream
        check("range_err_pre", int'(bus.range_err), 0);
        send_m(100, 50);
        send_m(7, 9);
        drive(1'b1, 12'd3329, 12'd0, 1'b1, 12'd0, 1'b0, 1'b1, acc);
        check("bad_accepted", int'(acc), 1);
        send_m(1234, 4);
        check("range_err_set", int'(bus.range_err), 1);
        for (int i = 0; i < 6; i++) send_m(int'($urandom_range(0, 3328)), int'($urandom_range(0, 3328)));
        drain();
        check("range_err_sticky", int'(bus.range_err), 1);

        // Reset with two words in flight
        lat_chk = 1;
        for (int i = 0; i < 100; i++)
            send_m(int'($urandom_range(0, 3328)), int'($urandom_range(0, 3328)));
        do_reset();
        send_d(10, 20, 3319, 1'b0);
        for (int i = 0; i < 9; i++) send_m(int'($urandom_range(0, 3328)), int'($urandom_range(0, 3328)));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/poly_sub_decode.md
# poly_sub_decode

Streaming decapsulation back-end that computes w' = v − sᵀu mod q one coefficient per cycle and decodes each difference to a message bit, the inverse of the encapsulation-side sum v = y + msg_poly + e_2. The block accepts coefficient pairs over a valid/ready stream, passes them through a 2-stage pipeline and emits the reduced coefficient, its decoded bit, and its index. It sits between the decapsulation polynomial-product datapath and the message byte packer.

## Interface
- DATA_WID, 12, coefficient width
- Q, 3329, Kyber modulus
- N_COEFF, 256, coefficients per polynomial; the index width is log2(N_COEFF)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- in_valid  input  1  input pair present
- in_ready  output  1  block accepts the input pair this cycle
- in_v  input  DATA_WID  coefficient of v; legal range 0..Q−1
- in_w  input  DATA_WID  coefficient of sᵀu; legal range 0..Q−1
- out_valid  output  1  output word present
- out_ready  input  1  downstream accepts the output word
- out_coeff  output  DATA_WID  (in_v − in_w) mod Q
- out_bit  output  1  decoded message bit
- out_idx  output  8  coefficient index, 0..N_COEFF−1
- out_last  output  1  high with out_idx == N_COEFF−1
- range_err  output  1  sticky flag: an accepted operand was ≥ Q

## Operation
- Input transfer occurs on in_valid & in_ready. Output transfer occurs on out_valid & out_ready.
- Global pipeline enable: en = !out_valid | out_ready. in_ready = en.
  - in_ready must not depend combinationally on in_valid.
- Stage 1, loaded when en:
  - Registers the 13-bit two's-complement diff = in_v − in_w.
  - Registers a valid bit (s1_valid = in_valid) and the current index counter value.
- Stage 2, loaded when en:
  - coeff = diff + Q if diff < 0, else diff. Result lies in 0..Q−1 for legal inputs.
  - bit = 1 iff 833 ≤ coeff ≤ 2496, i.e. round(2·coeff/Q) mod 2.
  - s2_valid = s1_valid. out_valid = s2_valid.
- Index counter:
  - 8-bit, increments on each input transfer.
  - Wraps N_COEFF−1 → 0, so consecutive polynomials stream back to back.
  - The index travels with its data, so out_idx always matches the coefficient it accompanies.
- range_err:
  - Set on any input transfer with in_v ≥ Q or in_w ≥ Q.
  - Cleared only by reset.
  - The corresponding out_coeff is unspecified but still emitted; the counter still advances.
- When stalled (out_valid & !out_ready), all pipeline registers and the counter hold.

## Timing
- Latency: an input accepted in cycle t appears on the outputs in cycle t+2 if out_ready stayed high.
- Throughput: 1 coefficient per cycle with out_ready held high. A full polynomial takes 256 transfers plus 2 cycles of drain.
- Bubbles (in_valid low) propagate as out_valid low; they are not collapsed.
- Outputs are stable while out_valid & !out_ready (AXI-style hold).
- Reset values:
  - out_valid, out_coeff, out_bit, out_idx, out_last, range_err = 0; stage-1 valid = 0; counter = 0.
  - in_ready = 1 in the first cycle after reset release.
- Reset mid-polynomial: in-flight words are dropped and the counter returns to 0. The next accepted pair is index 0.
- Simultaneous output transfer and new input acceptance in the same cycle is the normal full-throughput case and must not lose or duplicate data.

## Test plan
- Directed values with out_ready=1:
  - (in_v, in_w) = (5, 3) → out_coeff 2, bit 0.
  - (3, 5) → 3327, bit 0.
  - (2000, 0) → 2000, bit 1.
  - (0, 0) → 0, bit 0.
  - Each result appears exactly 2 cycles after acceptance.
- Decode boundaries: stimuli giving coeff 832, 833, 2496, 2497 → bits 0, 1, 1, 0. Also (0, 1) → 3328, bit 0.
- Full stream: 512 random legal pairs back to back → 512 outputs matching a reference model. out_last high at outputs 255 and 511 only; out_idx wraps to 0 at output 256.
- Backpressure: random out_ready (50%) with random in_valid over 256 pairs → no loss or duplication, outputs held stable while stalled, in_ready low exactly when out_valid & !out_ready.
- Range error: a single pair (3329, 0) mid-stream → range_err rises after acceptance and stays 1. Later legal pairs still produce correct results and indices.
- Reset mid-frame: assert rst_n low after 100 accepted pairs with 2 words in flight → all outputs 0 during reset. After release, the first accepted pair yields out_idx 0 and no stale words appear.
